rslt_accumulator: RTL and testbench

RSLT_ACCUMULATOR -- requirements
Module: rslt_accumulator

---
 rtl/rslt_accumulator.sv | 145 ++++++++++++++
 tb/tb_rslt_accumulator.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rslt_accumulator.sv
// Frame accumulator: sums signed partial results per input frame and emits one
// saturated, scaled result beat per frame, grouped into packets of GROUP_SIZE.
module rslt_accumulator #(
    parameter int RSLT_WIDTH = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int OUT_WIDTH  = 16,
    parameter int OUT_SHIFT  = 0,
    parameter int GROUP_SIZE = 4,
    parameter int ID_WIDTH   = 1,
    parameter int DEST_WIDTH = 1,
    parameter int USER_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [RSLT_WIDTH-1:0] s_axis_rslt_tdata,
    input  logic                  s_axis_rslt_tvalid,
    output logic                  s_axis_rslt_tready,
    input  logic                  s_axis_rslt_tlast,
    input  logic [ID_WIDTH-1:0]   s_axis_rslt_tid,
    input  logic [DEST_WIDTH-1:0] s_axis_rslt_tdest,
    input  logic [USER_WIDTH-1:0] s_axis_rslt_tuser,
    output logic [OUT_WIDTH-1:0]  m_axis_data_tdata,
    output logic                  m_axis_data_tvalid,
    input  logic                  m_axis_data_tready,
    output logic                  m_axis_data_tlast,
    output logic [ID_WIDTH-1:0]   m_axis_data_tid,
    output logic [DEST_WIDTH-1:0] m_axis_data_tdest,
    output logic [USER_WIDTH-1:0] m_axis_data_tuser,
    output logic                  err_saturate
);

    localparam int CNT_W = (GROUP_SIZE > 1) ? $clog2(GROUP_SIZE) : 1;
    localparam int WW    = (ACC_WIDTH > OUT_WIDTH) ? ACC_WIDTH : OUT_WIDTH;

    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic signed [WW-1:0] OUT_MAX_W = {{(WW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [WW-1:0] OUT_MIN_W = {{(WW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] GRP_LAST = CNT_W'(GROUP_SIZE - 1);

    typedef enum logic {ACC, OUT} state_t;

    state_t state, state_next;

    logic signed [ACC_WIDTH-1:0] acc, acc_next, din, shifted;
    logic signed [ACC_WIDTH:0]   sum;
    logic signed [WW-1:0]        wide;
    logic                        acc_sat, out_sat, first, in_hs, out_hs;
    logic [CNT_W-1:0]            grp;
    logic [ID_WIDTH-1:0]         id_q;
    logic [DEST_WIDTH-1:0]       dest_q;
    logic [USER_WIDTH-1:0]       user_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ACC;
        else     state <= state_next;
    end

    always_comb begin
        state_next         = state;
        s_axis_rslt_tready = 1'b0;
        m_axis_data_tvalid = 1'b0;
        m_axis_data_tlast  = 1'b0;
        case (state)
            ACC: begin
                s_axis_rslt_tready = 1'b1;
                if (s_axis_rslt_tvalid && s_axis_rslt_tlast) state_next = OUT;
            end
            OUT: begin
                m_axis_data_tvalid = 1'b1;
                m_axis_data_tlast  = (grp == GRP_LAST);
                if (m_axis_data_tready) state_next = ACC;
            end
            default: state_next = ACC;
        endcase
    end

    assign in_hs  = s_axis_rslt_tvalid & s_axis_rslt_tready;
    assign out_hs = m_axis_data_tvalid & m_axis_data_tready;

    // One extra bit of sum exposes signed overflow as a mismatch of the top two bits.
    always_comb begin
        din     = ACC_WIDTH'(signed'(s_axis_rslt_tdata));
        sum     = (ACC_WIDTH+1)'(acc) + (ACC_WIDTH+1)'(din);
        acc_sat = 1'b0;
        if (first) begin
            acc_next = din;
        end else if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]) begin
            acc_sat  = 1'b1;
            acc_next = sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        end else begin
            acc_next = sum[ACC_WIDTH-1:0];
        end
    end

    always_comb begin
        shifted = acc >>> OUT_SHIFT;
        wide    = WW'(shifted);
        out_sat = 1'b0;
        if (wide > OUT_MAX_W) begin
            out_sat           = 1'b1;
            m_axis_data_tdata = OUT_WIDTH'(OUT_MAX_W);
        end else if (wide < OUT_MIN_W) begin
            out_sat           = 1'b1;
            m_axis_data_tdata = OUT_WIDTH'(OUT_MIN_W);
        end else begin
            m_axis_data_tdata = OUT_WIDTH'(wide);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc          <= '0;
            first        <= 1'b1;
            grp          <= '0;
            err_saturate <= 1'b0;
            id_q         <= '0;
            dest_q       <= '0;
            user_q       <= '0;
        end else begin
            if (in_hs) begin
                acc   <= acc_next;
                first <= 1'b0;
                if (first) begin
                    id_q   <= s_axis_rslt_tid;
                    dest_q <= s_axis_rslt_tdest;
                    user_q <= s_axis_rslt_tuser;
                end else begin
                    user_q <= user_q | s_axis_rslt_tuser;
                end
                if (acc_sat) err_saturate <= 1'b1;
            end
            if (out_hs) begin
                first <= 1'b1;
                grp   <= (grp == GRP_LAST) ? '0 : grp + 1'b1;
                if (out_sat) err_saturate <= 1'b1;
            end
        end
    end

    assign m_axis_data_tid   = id_q;
    assign m_axis_data_tdest = dest_q;
    assign m_axis_data_tuser = user_q;

endmodule

// File: tb/tb_rslt_accumulator.sv
// Directed bench for rslt_accumulator: two instances (OUT_SHIFT 0 and 2) share
// stimulus; a scoreboard of model results is compared at each output beat.
module tb_rslt_accumulator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic signed [15:0] s_data;
    logic               s_valid, s_last, m_ready;
    logic [1:0]         s_id, s_dest, s_user;

    logic        s_ready0, m_valid0, m_last0, err0;
    logic [15:0] m_data0;
    logic [1:0]  m_id0, m_dest0, m_user0;
    logic        s_ready1, m_valid1, m_last1, err1;
    logic [15:0] m_data1;
    logic [1:0]  m_id1, m_dest1, m_user1;

    rslt_accumulator #(.OUT_SHIFT(0), .GROUP_SIZE(4), .ID_WIDTH(2), .DEST_WIDTH(2), .USER_WIDTH(2)) dut0 (
        .clk(clk), .rst(rst),
        .s_axis_rslt_tdata(s_data), .s_axis_rslt_tvalid(s_valid), .s_axis_rslt_tready(s_ready0),
        .s_axis_rslt_tlast(s_last), .s_axis_rslt_tid(s_id), .s_axis_rslt_tdest(s_dest),
        .s_axis_rslt_tuser(s_user),
        .m_axis_data_tdata(m_data0), .m_axis_data_tvalid(m_valid0), .m_axis_data_tready(m_ready),
        .m_axis_data_tlast(m_last0), .m_axis_data_tid(m_id0), .m_axis_data_tdest(m_dest0),
        .m_axis_data_tuser(m_user0), .err_saturate(err0)
    );

    rslt_accumulator #(.OUT_SHIFT(2), .GROUP_SIZE(4), .ID_WIDTH(2), .DEST_WIDTH(2), .USER_WIDTH(2)) dut1 (
        .clk(clk), .rst(rst),
        .s_axis_rslt_tdata(s_data), .s_axis_rslt_tvalid(s_valid), .s_axis_rslt_tready(s_ready1),
        .s_axis_rslt_tlast(s_last), .s_axis_rslt_tid(s_id), .s_axis_rslt_tdest(s_dest),
        .s_axis_rslt_tuser(s_user),
        .m_axis_data_tdata(m_data1), .m_axis_data_tvalid(m_valid1), .m_axis_data_tready(m_ready),
        .m_axis_data_tlast(m_last1), .m_axis_data_tid(m_id1), .m_axis_data_tdest(m_dest1),
        .m_axis_data_tuser(m_user1), .err_saturate(err1)
    );

    typedef struct {
        longint     d0;
        longint     d1;
        logic       last;
        logic [1:0] id;
        logic [1:0] dest;
        logic [1:0] user;
        logic       sat;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    longint     m_acc;
    bit         m_first;
    logic [1:0] m_id, m_dest, m_user;
    int         m_grp;
    bit         m_err;

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint sat(input longint v, input int w);
        longint mx, mn;
        mx = (64'sd1 <<< (w - 1)) - 1;
        mn = -(64'sd1 <<< (w - 1));
        if (v > mx) return mx;
        if (v < mn) return mn;
        return v;
    endfunction

    task automatic model_reset();
        m_acc   = 0;
        m_first = 1'b1;
        m_id    = '0;
        m_dest  = '0;
        m_user  = '0;
        m_grp   = 0;
        m_err   = 1'b0;
        sb.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        s_valid = 1'b0;
        m_ready = 1'b0;
        #1;
        check("rst_err", err0, 0);
        check("rst_valid", m_valid0, 0);
        check("rst_last", m_last0, 0);
        check("rst_s_ready", s_ready0, 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic send_beat(input longint d, input bit last, input logic [1:0] id,
                             input logic [1:0] dest, input logic [1:0] user);
        exp_t e;
        int   n;
        if (m_first) begin
            m_acc  = d;
            m_id   = id;
            m_dest = dest;
            m_user = user;
        end else begin
            if (sat(m_acc + d, 32) != m_acc + d) m_err = 1'b1;
            m_acc  = sat(m_acc + d, 32);
            m_user = m_user | user;
        end
        m_first = 1'b0;
        if (last) begin
            e.d0   = sat(m_acc, 16);
            e.d1   = sat(m_acc >>> 2, 16);
            e.last = (m_grp == 3);
            e.id   = m_id;
            e.dest = m_dest;
            e.user = m_user;
            e.sat  = (sat(m_acc, 16) != m_acc);
            sb.push_back(e);
            m_grp   = (m_grp + 1) % 4;
            m_first = 1'b1;
        end
        s_data  = d[15:0];
        s_last  = last;
        s_id    = id;
        s_dest  = dest;
        s_user  = user;
        s_valid = 1'b1;
        n = 0;
        while (!s_ready0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready0) begin
            check("s_ready_timeout", s_ready0, 1);
            s_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0;
        if (last) check("latency_valid", m_valid0, 1);
    endtask

    task automatic get_output(input int hold);
        exp_t e;
        int   n;
        m_ready = 1'b0;
        n = 0;
        while (!m_valid0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!m_valid0) begin
            check("out_timeout", m_valid0, 1);
            return;
        end
        if (sb.size() == 0) begin
            check("unexpected_output", m_valid0, 0);
            return;
        end
        e = sb.pop_front();
        for (int i = 0; i < hold; i++) begin
            check("hold_data", $signed(m_data0), e.d0);
            check("hold_id", m_id0, e.id);
            check("hold_dest", m_dest0, e.dest);
            check("hold_user", m_user0, e.user);
            check("hold_s_ready", s_ready0, 0);
            check("hold_valid", m_valid0, 1);
            @(negedge clk);
        end
        check("data0", $signed(m_data0), e.d0);
        check("data1", $signed(m_data1), e.d1);
        check("valid1", m_valid1, 1);
        check("last0", m_last0, e.last);
        check("last1", m_last1, e.last);
        check("id0", m_id0, e.id);
        check("dest0", m_dest0, e.dest);
        check("user0", m_user0, e.user);
        check("id1", m_id1, e.id);
        check("dest1", m_dest1, e.dest);
        check("user1", m_user1, e.user);
        m_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        m_ready = 1'b0;
        m_err   = m_err | e.sat;
        check("valid_drop", m_valid0, 0);
        check("s_ready_back", s_ready0, 1);
        check("s_ready1_back", s_ready1, 1);
        check("err", err0, m_err);
    endtask

    initial begin
        rst     = 1'b1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = '0;
        s_id    = '0;
        s_dest  = '0;
        s_user  = '0;
        m_ready = 1'b0;
        model_reset();
        do_reset();

        send_beat(100, 0, 2'd0, 2'd0, 2'd0);
        send_beat(-30, 0, 2'd0, 2'd0, 2'd0);
        send_beat(5,   1, 2'd0, 2'd0, 2'd0);
        get_output(0);

        send_beat(-8, 0, 2'd1, 2'd2, 2'd0);
        send_beat(-8, 1, 2'd0, 2'd0, 2'd0);
        get_output(0);

        send_beat(10, 0, 2'd2, 2'd1, 2'd1);
        send_beat(20, 1, 2'd0, 2'd0, 2'd2);
        get_output(5);

        send_beat(9, 1, 2'd3, 2'd3, 2'd0);
        get_output(0);

        for (int v = 1; v <= 4; v++) begin
            send_beat(longint'(v), 1, 2'(v), 2'(v + 1), 2'd0);
            get_output(0);
        end

        for (int i = 0; i < 3; i++) send_beat(32767, (i == 2), 2'd1, 2'd1, 2'd1);
        get_output(0);

        send_beat(50, 0, 2'd0, 2'd0, 2'd0);
        send_beat(60, 0, 2'd0, 2'd0, 2'd0);
        do_reset();
        send_beat(7, 1, 2'd2, 2'd0, 2'd0);
        get_output(0);
        for (int i = 0; i < 3; i++) begin
            send_beat(1, 1, 2'd0, 2'd0, 2'd0);
            get_output(0);
        end
        check("err1_final", err1, 0);
        check("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
